// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle for the instruction fetch unit: memory request side, redirect/hold
// controls and the instruction stream toward the decoder.
interface instruction_fetch_unit_if;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [31:0] mem_read_data;
  logic        mem_ready;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        freeze;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;

  modport master (
    output mem_address, mem_read, inst_valid, instruction, inst_pc,
    input  mem_read_data, mem_ready, branch_taken, branch_address, freeze, inst_ready
  );

  modport slave (
    input  mem_address, mem_read, inst_valid, instruction, inst_pc,
    output mem_read_data, mem_ready, branch_taken, branch_address, freeze, inst_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Sequential instruction fetcher with a small FIFO buffer, branch flush/redirect
// and a DISCARD state that drains an in-flight request after a redirect.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic                       clk,
  input logic                       rst,
  instruction_fetch_unit_if.master  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DISCARD, HOLD} state_t;

  state_t             state_reg, state_next;
  logic [31:0]        fetch_pc_reg, fetch_pc_next;
  logic [31:0]        addr_reg, addr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]   count_reg, count_next;

  logic               push, pop, slot_free, can_start;
  logic               mem_read_int, inst_valid_int;
  logic [63:0]        head;
  logic [31:0]        instruction_int, inst_pc_int;
  logic [63:0]        entry_rd [FIFO_DEPTH];

  // A branch cancels both the response landing this cycle and any pop.
  assign push = (state_reg == FETCH) && bus.mem_ready && !bus.branch_taken;
  assign pop  = inst_valid_int && bus.inst_ready && !bus.branch_taken;

  always_comb begin
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    if (bus.branch_taken) begin
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      count_next = count_reg + CNT_W'(1);
      else if (!push && pop) count_next = count_reg - CNT_W'(1);
    end
  end

  assign slot_free = count_next < CNT_W'(FIFO_DEPTH);
  assign can_start = slot_free && !bus.freeze;

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (bus.branch_taken)
      fetch_pc_next = {bus.branch_address[31:2], 2'b00};
    else if (push)
      fetch_pc_next = fetch_pc_reg + 32'd4;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = bus.freeze ? HOLD : FETCH;
      FETCH: begin
        if (bus.mem_ready)         state_next = can_start ? FETCH : HOLD;
        else if (bus.branch_taken) state_next = DISCARD;
      end
      DISCARD: if (bus.mem_ready) state_next = can_start ? FETCH : HOLD;
      HOLD:    if (can_start)     state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  // Output logic, decoded from registered state only
  always_comb begin
    mem_read_int    = (state_reg == FETCH) || (state_reg == DISCARD);
    inst_valid_int  = (count_reg != '0);
    head            = entry_rd[rd_ptr_reg];
    instruction_int = inst_valid_int ? head[63:32] : 32'd0;
    inst_pc_int     = inst_valid_int ? head[31:0]  : 32'd0;
  end

  // The request address only moves when a new request begins, so DISCARD keeps the old one.
  assign addr_next = (state_next == FETCH) ? fetch_pc_next : addr_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_reg <= RESET_PC;
      addr_reg     <= RESET_PC;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      addr_reg     <= addr_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      logic [63:0] data_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          data_reg <= '0;
        else if (push && (wr_ptr_reg == PTR_W'(gi)))
          data_reg <= {bus.mem_read_data, addr_reg};
      end
      assign entry_rd[gi] = data_reg;
    end
  endgenerate

  assign bus.mem_read    = mem_read_int;
  assign bus.mem_address = addr_reg;
  assign bus.inst_valid  = inst_valid_int;
  assign bus.instruction = instruction_int;
  assign bus.inst_pc     = inst_pc_int;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus a randomized run
// checked against a stream model (expected pc advances by 4, branches reload it).
module tb_instruction_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int lat = 0;
  bit rand_mode = 1'b0;
  bit ovr_en = 1'b0;
  bit ovr_val = 1'b0;
  int cur_wait = 0;
  int hs_cnt = 0;

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    return (a[7:0] * 8'd7) ^ a[23:16] ^ a[31:24] ^ 8'h3C;
  endfunction

  // Big-endian: the byte at the word address sits in [31:24].
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {byte_at(a), byte_at(a + 32'd1), byte_at(a + 32'd2), byte_at(a + 32'd3)};
  endfunction

  // Memory responder: fixed latency per request, random strobes, or a forced level.
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_read_data = 32'd0;
    forever begin
      @(negedge clk);
      bus.mem_read_data = word_at(bus.mem_address);
      if (ovr_en) bus.mem_ready = ovr_val;
      else if (rand_mode) bus.mem_ready = ($urandom_range(0, 2) == 0);
      else if (!bus.mem_read) begin bus.mem_ready = 1'b0; cur_wait = 0; end
      else if (cur_wait >= lat) begin bus.mem_ready = 1'b1; cur_wait = 0; end
      else begin bus.mem_ready = 1'b0; cur_wait++; end
      if (bus.mem_read && bus.mem_ready) hs_cnt++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int latency);
    rst = 1'b0;
    bus.branch_taken = 1'b0;
    bus.freeze = 1'b0;
    rand_mode = 1'b0;
    ovr_en = 1'b0;
    lat = latency;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.inst_ready = 1'b0;
    step();
    total_cnt++;
    if (bus.mem_read !== 1'b0) $display("FAIL reset_mem_read: got %b want 0", bus.mem_read);
    else pass_cnt++;
    total_cnt++;
    if (bus.mem_address !== RESET_PC) $display("FAIL reset_mem_address: got %h want %h", bus.mem_address, RESET_PC);
    else pass_cnt++;
    total_cnt++;
    if (bus.inst_valid !== 1'b0) $display("FAIL reset_inst_valid: got %b want 0", bus.inst_valid);
    else pass_cnt++;
    total_cnt++;
    if ({bus.instruction, bus.inst_pc} !== 64'd0)
      $display("FAIL reset_inst_outputs: got %h/%h want 0/0", bus.instruction, bus.inst_pc);
    else pass_cnt++;
    lat = 0;
    rst = 1'b1;
    step();
    total_cnt++;
    if ({bus.mem_read, bus.mem_address} !== {1'b1, RESET_PC})
      $display("FAIL reset_first_fetch: got read=%b addr=%h want read=1 addr=%h", bus.mem_read, bus.mem_address, RESET_PC);
    else pass_cnt++;
    $display("reset: released, first request at %h", bus.mem_address);
  endtask

  task automatic test_zero_wait();
    int n;
    logic [31:0] e;
    do_reset(0);
    bus.inst_ready = 1'b1;
    n = 0;
    step();
    while (!bus.inst_valid && n < 10) begin step(); n++; end
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      e = RESET_PC + 32'(4 * k);
      total_cnt++;
      if ({bus.inst_valid, bus.inst_pc, bus.instruction} !== {1'b1, e, word_at(e)})
        $display("FAIL zero_wait_stream[%0d]: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                 k, bus.inst_valid, bus.inst_pc, bus.instruction, e, word_at(e));
      else pass_cnt++;
      $display("zero_wait: pc=%h ins=%h", bus.inst_pc, bus.instruction);
    end
  endtask

  task automatic test_backpressure();
    do_reset(0);
    bus.inst_ready = 1'b0;
    hs_cnt = 0;
    repeat (8) step();
    total_cnt++;
    if (hs_cnt !== 2) $display("FAIL backpressure_push_count: got %0d want 2", hs_cnt);
    else pass_cnt++;
    total_cnt++;
    if ({bus.mem_read, bus.inst_valid, bus.inst_pc} !== {1'b0, 1'b1, RESET_PC})
      $display("FAIL backpressure_full: got read=%b v=%b pc=%h want read=0 v=1 pc=%h",
               bus.mem_read, bus.inst_valid, bus.inst_pc, RESET_PC);
    else pass_cnt++;
    bus.inst_ready = 1'b1;
    step();
    total_cnt++;
    if ({bus.mem_read, bus.mem_address, bus.inst_valid, bus.inst_pc} !== {1'b1, RESET_PC + 32'd8, 1'b1, RESET_PC + 32'd4})
      $display("FAIL backpressure_resume: got read=%b addr=%h v=%b pc=%h want read=1 addr=%h v=1 pc=%h",
               bus.mem_read, bus.mem_address, bus.inst_valid, bus.inst_pc, RESET_PC + 32'd8, RESET_PC + 32'd4);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({bus.inst_valid, bus.inst_pc, bus.instruction} !== {1'b1, RESET_PC + 32'd8, word_at(RESET_PC + 32'd8)})
      $display("FAIL backpressure_third: got v=%b pc=%h ins=%h want v=1 pc=%h", bus.inst_valid, bus.inst_pc,
               bus.instruction, RESET_PC + 32'd8);
    else pass_cnt++;
    $display("backpressure: resumed, head pc=%h", bus.inst_pc);
  endtask

  task automatic test_branch_discard();
    int n;
    do_reset(3);
    bus.inst_ready = 1'b1;
    n = 0;
    step();
    while (!bus.mem_read && n < 10) begin step(); n++; end
    bus.branch_taken = 1'b1;
    bus.branch_address = 32'h0000_0103;
    step();
    bus.branch_taken = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      total_cnt++;
      if ({bus.mem_read, bus.mem_address} !== {1'b1, RESET_PC})
        $display("FAIL discard_hold[%0d]: got read=%b addr=%h want read=1 addr=%h", k, bus.mem_read, bus.mem_address, RESET_PC);
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if ({bus.mem_read, bus.mem_address, bus.inst_valid} !== {1'b1, 32'h0000_0100, 1'b0})
      $display("FAIL discard_redirect: got read=%b addr=%h v=%b want read=1 addr=00000100 v=0",
               bus.mem_read, bus.mem_address, bus.inst_valid);
    else pass_cnt++;
    n = 0;
    while (!bus.inst_valid && n < 12) begin step(); n++; end
    total_cnt++;
    if ({bus.inst_valid, bus.inst_pc, bus.instruction} !== {1'b1, 32'h0000_0100, word_at(32'h0000_0100)})
      $display("FAIL discard_first_delivery: got v=%b pc=%h ins=%h want v=1 pc=00000100 ins=%h",
               bus.inst_valid, bus.inst_pc, bus.instruction, word_at(32'h0000_0100));
    else pass_cnt++;
    $display("branch_discard: first delivered pc=%h", bus.inst_pc);
  endtask

  task automatic test_branch_flush();
    int n;
    do_reset(0);
    bus.inst_ready = 1'b0;
    repeat (6) step();
    total_cnt++;
    if ({bus.inst_valid, bus.inst_pc, bus.mem_read} !== {1'b1, RESET_PC, 1'b0})
      $display("FAIL flush_precondition: got v=%b pc=%h read=%b want v=1 pc=%h read=0",
               bus.inst_valid, bus.inst_pc, bus.mem_read, RESET_PC);
    else pass_cnt++;
    bus.inst_ready = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_address = 32'h0000_0202;
    step();
    bus.branch_taken = 1'b0;
    total_cnt++;
    if ({bus.inst_valid, bus.mem_read, bus.mem_address} !== {1'b0, 1'b1, 32'h0000_0200})
      $display("FAIL flush_empty: got v=%b read=%b addr=%h want v=0 read=1 addr=00000200",
               bus.inst_valid, bus.mem_read, bus.mem_address);
    else pass_cnt++;
    n = 0;
    while (!bus.inst_valid && n < 10) begin step(); n++; end
    total_cnt++;
    if ({bus.inst_valid, bus.inst_pc} !== {1'b1, 32'h0000_0200})
      $display("FAIL flush_first_delivery: got v=%b pc=%h want v=1 pc=00000200", bus.inst_valid, bus.inst_pc);
    else pass_cnt++;
    $display("branch_flush: first delivered pc=%h", bus.inst_pc);
  endtask

  task automatic test_wrap();
    int n;
    logic [31:0] e;
    do_reset(0);
    bus.inst_ready = 1'b1;
    repeat (4) step();
    bus.branch_taken = 1'b1;
    bus.branch_address = 32'hFFFF_FFF8;
    step();
    bus.branch_taken = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!bus.inst_valid && n < 10) begin step(); n++; end
      e = 32'hFFFF_FFF8 + 32'(4 * k);
      total_cnt++;
      if ({bus.inst_valid, bus.inst_pc, bus.instruction} !== {1'b1, e, word_at(e)})
        $display("FAIL wrap_stream[%0d]: got v=%b pc=%h ins=%h want pc=%h ins=%h",
                 k, bus.inst_valid, bus.inst_pc, bus.instruction, e, word_at(e));
      else pass_cnt++;
      $display("wrap: pc=%h ins=%h", bus.inst_pc, bus.instruction);
      step();
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset(0);
    bus.inst_ready = 1'b1;
    repeat (2) step();
    bus.branch_taken = 1'b1;
    bus.branch_address = 32'h0000_0040;
    step();
    bus.branch_taken = 1'b0;
    repeat (3) step();
    lat = 3;
    repeat (2) step();
    total_cnt++;
    if (bus.mem_read !== 1'b1) $display("FAIL midreset_outstanding: got read=%b want 1", bus.mem_read);
    else pass_cnt++;
    #2;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({bus.mem_read, bus.mem_address, bus.inst_valid, bus.instruction, bus.inst_pc} !== {1'b0, RESET_PC, 1'b0, 64'd0})
      $display("FAIL midreset_async: got read=%b addr=%h v=%b ins=%h pc=%h want read=0 addr=%h v=0 ins=0 pc=0",
               bus.mem_read, bus.mem_address, bus.inst_valid, bus.instruction, bus.inst_pc, RESET_PC);
    else pass_cnt++;
    ovr_en = 1'b1;
    ovr_val = 1'b1;
    step();
    step();
    total_cnt++;
    if ({bus.inst_valid, bus.mem_read} !== 2'b00)
      $display("FAIL midreset_ignore_ready: got v=%b read=%b want 0/0", bus.inst_valid, bus.mem_read);
    else pass_cnt++;
    ovr_en = 1'b0;
    lat = 0;
    rst = 1'b1;
    step();
    total_cnt++;
    if ({bus.mem_read, bus.mem_address} !== {1'b1, RESET_PC})
      $display("FAIL midreset_restart: got read=%b addr=%h want read=1 addr=%h", bus.mem_read, bus.mem_address, RESET_PC);
    else pass_cnt++;
    n = 0;
    while (!bus.inst_valid && n < 10) begin step(); n++; end
    total_cnt++;
    if ({bus.inst_valid, bus.inst_pc, bus.instruction} !== {1'b1, RESET_PC, word_at(RESET_PC)})
      $display("FAIL midreset_first_delivery: got v=%b pc=%h ins=%h want v=1 pc=%h",
               bus.inst_valid, bus.inst_pc, bus.instruction, RESET_PC);
    else pass_cnt++;
    $display("reset_mid: restarted at pc=%h", bus.inst_pc);
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    bit prev_branch, prev_stall, br, rdy;
    int delivered;
    do_reset(0);
    bus.inst_ready = 1'b0;
    rand_mode = 1'b1;
    exp_pc = RESET_PC;
    prev_addr = '0;
    prev_branch = 1'b0;
    prev_stall = 1'b0;
    delivered = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      step();
      if (prev_branch) begin
        total_cnt++;
        if (bus.inst_valid !== 1'b0) $display("FAIL rand_flush@%0d: got v=%b want 0", cyc, bus.inst_valid);
        else pass_cnt++;
      end
      if (prev_stall) begin
        total_cnt++;
        if ({bus.mem_read, bus.mem_address} !== {1'b1, prev_addr})
          $display("FAIL rand_req_stable@%0d: got read=%b addr=%h want read=1 addr=%h",
                   cyc, bus.mem_read, bus.mem_address, prev_addr);
        else pass_cnt++;
      end
      prev_stall = bus.mem_read && !bus.mem_ready;
      prev_addr = bus.mem_address;
      br = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      bus.branch_taken = br;
      bus.branch_address = $urandom;
      bus.inst_ready = rdy;
      bus.freeze = ($urandom_range(0, 7) == 0);
      if (br) begin
        exp_pc = {bus.branch_address[31:2], 2'b00};
      end else if (bus.inst_valid && rdy) begin
        total_cnt++;
        if ({bus.inst_pc, bus.instruction} !== {exp_pc, word_at(exp_pc)})
          $display("FAIL rand_stream@%0d: got pc=%h ins=%h want pc=%h ins=%h",
                   cyc, bus.inst_pc, bus.instruction, exp_pc, word_at(exp_pc));
        else pass_cnt++;
        $display("random: pc=%h ins=%h", bus.inst_pc, bus.instruction);
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      prev_branch = br;
    end
    bus.branch_taken = 1'b0;
    bus.freeze = 1'b0;
    rand_mode = 1'b0;
    total_cnt++;
    if (delivered < 60) $display("FAIL rand_progress: got %0d deliveries want at least 60", delivered);
    else pass_cnt++;
  endtask

  initial begin
    bus.branch_taken = 1'b0;
    bus.branch_address = 32'd0;
    bus.freeze = 1'b0;
    bus.inst_ready = 1'b0;
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_branch_discard();
    test_branch_flush();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2: instruction buffer entries; legal values 2 or 4.
REQ-003 clk  input  1  the block's only clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 mem_address  output  32  byte address of the requested instruction word.
REQ-006 mem_read  output  1  read request to instruction memory.
REQ-007 mem_read_data  input  32  returned word, big-endian: byte at address in [31:24].
REQ-008 mem_ready  input  1  response strobe; mem_read_data valid when mem_read and mem_ready are both high.
REQ-009 branch_taken  input  1  one-cycle redirect request.
REQ-010 branch_address  input  32  redirect target; bits [1:0] ignored and treated as 0.
REQ-011 freeze  input  1  hold: no new memory request starts while high.
REQ-012 inst_valid  output  1  buffer head holds a valid instruction.
REQ-013 inst_ready  input  1  consumer accepts head when inst_valid and inst_ready are both high.
REQ-014 instruction  output  32  head instruction word.
REQ-015 inst_pc  output  32  byte address the head instruction was fetched from.

Function
REQ-016 All outputs registered or driven from registered state only; no combinational path from any input to mem_read or mem_address.
REQ-017 States: IDLE, FETCH, DISCARD, HOLD.
REQ-018 IDLE: entered only by reset; moves to FETCH on the first clock edge after reset deasserts.
REQ-019 FETCH: mem_read=1; mem_address=fetch_pc; both held stable until the cycle mem_ready=1.
REQ-020 FETCH on mem_ready with no branch: push {mem_read_data, fetch_pc}; fetch_pc += 4, modulo 2^32 with wrap from 32'hFFFF_FFFC to 0.
REQ-021 After a push: stay in FETCH if the buffer has a free slot and freeze=0; otherwise go to HOLD.
REQ-022 HOLD: mem_read=0; return to FETCH once a slot is free and freeze=0.
REQ-023 Buffer occupancy accounts for a same-cycle pop; a push never overwrites an unconsumed entry.
REQ-024 Pops follow FIFO order; inst_valid=0 when the buffer is empty; instruction and inst_pc are don't-care while inst_valid=0.
REQ-025 Push and pop in the same cycle are both performed; occupancy stays unchanged.
REQ-026 branch_taken flushes all buffer entries in that cycle, so inst_valid=0 on the next cycle; any pop in that cycle is discarded.
REQ-027 branch_taken sets fetch_pc to {branch_address[31:2], 2'b00}.
REQ-028 branch_taken in FETCH with mem_ready=0: go to DISCARD; mem_read and the old mem_address stay held.
REQ-029 branch_taken in FETCH with mem_ready=1: the response is dropped; next state follows REQ-021 using the new fetch_pc.
REQ-030 DISCARD: hold the old request until mem_ready; drop the response; then go to FETCH (or HOLD if freeze=1) at the new fetch_pc.
REQ-031 A second branch_taken while in DISCARD overwrites the target; the last target wins.
REQ-032 freeze never aborts an outstanding request; it only blocks starting a new one.
REQ-033 branch_taken in IDLE or HOLD: flush and redirect only; no transaction is outstanding.

Reset
REQ-034 Asserting rst (low) forces immediately: state=IDLE, fetch_pc=RESET_PC, buffer empty, mem_read=0, mem_address=RESET_PC, inst_valid=0, instruction=0, inst_pc=0.
REQ-035 Reset during an outstanding request abandons it; responses arriving while in IDLE are ignored.

Verification
REQ-036 Zero-wait memory (mem_ready tied 1), inst_ready=1, RESET_PC=0 -> inst_pc = 0,4,8,... on consecutive cycles; instruction equals the stored big-endian words.
REQ-037 inst_ready=0, FIFO_DEPTH=2 -> exactly two pushes (pc 0,4), then mem_read=0; raise inst_ready -> pc 0,4 delivered, fetch resumes at 8.
REQ-038 mem_ready delayed 3 cycles; branch_taken to 32'h0000_0103 in the first wait cycle -> address 0 held until mem_ready, its word dropped, next request at 32'h0000_0100, first delivered inst_pc=32'h100.
REQ-039 branch_taken with 2 buffered entries and inst_ready=1 in the same cycle -> no instruction delivered from the old stream; inst_valid=0 next cycle.
REQ-040 fetch_pc=32'hFFFF_FFFC -> next fetch address 0.
REQ-041 rst low mid-request, with mem_ready pulsed while low -> no push; after release, first request at RESET_PC.
